// File: rtl/debug_pkg.sv
// Shared constants for the board-level step/display companion of the MIPS core.
//   - Step FSM state encodings (kept as plain localparams so older tools and
//     checkers can compare against fixed numeric codes).
//   - Active-low seven-segment patterns, ordered {g,f,e,d,c,b,a}.
package debug_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HIGH     = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to seven-segment decoder.
// Ports:
//   hex_i  [3:0]  nibble to display
//   seg_o  [6:0]  active-low segments {g,f,e,d,c,b,a}
module hex_to_seg
  import debug_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/step_display_ctrl.sv
// Board-level companion stage for the pipelined MIPS core.
//   - Debounces the step push-button and emits exactly one PULSE_CYCLES-wide
//     cpuClk pulse per debounced press.
//   - Registers the switch register select towards the core (regInput).
//   - Scans a 4-digit common-anode display showing 16 bits of the PC or of
//     the selected register, latched once per frame so digits never tear.
// Ports:
//   clk, rst_n         board clock (rising edge), async active-low reset
//   stepBtn            raw bouncy step button, active-high, asynchronous
//   modeSel, halfSel   0/1 = PC/register, 0/1 = low/high half-word
//   regSel [4:0]       register number from switches
//   pcValue, regValue  32-bit PC and register read data from the core
//   cpuClk             step clock to the core
//   regInput [4:0]     register select to the core
//   anode [3:0]        digit enables, active-low
//   cathode [6:0]      segments {g,f,e,d,c,b,a}, active-low
//   dp                 decimal point, active-low (lit on digit 0 in register mode)
//   dbgState [1:0]     current step FSM state, for observation only
module step_display_ctrl
  import debug_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  PULSE_CYCLES    = 8'd4,
  parameter int          SCAN_BITS       = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stepBtn,
  input  logic        modeSel,
  input  logic        halfSel,
  input  logic [4:0]  regSel,
  input  logic [31:0] pcValue,
  input  logic [31:0] regValue,
  output logic        cpuClk,
  output logic [4:0]  regInput,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic [1:0]  dbgState
);

  // ---------------- button synchroniser + debouncer ----------------
  logic        sync1_q, sync2_q;
  logic        stable_q, stable_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        stable_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
  end

  // The FSM reacts to the debounced rise on the same edge that stable_q
  // updates, so cpuClk rises together with the new stable level.
  logic press;
  assign press = stable_d & ~stable_q;

  // ---------------- step FSM ----------------
  logic [1:0] state_q, state_d;
  logic [7:0] pulse_cnt_q, pulse_cnt_d;
  logic       cpu_clk_q, cpu_clk_d;

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    cpu_clk_d   = cpu_clk_q;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d     = ST_HIGH;
          cpu_clk_d   = 1'b1;
          pulse_cnt_d = '0;
        end
      end
      ST_HIGH: begin
        // Button level is ignored here: a release cannot cut the pulse short.
        if (pulse_cnt_q == PULSE_CYCLES - 8'd1) begin
          state_d     = ST_WAIT_REL;
          cpu_clk_d   = 1'b0;
          pulse_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
      end
      ST_WAIT_REL: begin
        if (!stable_q) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        cpu_clk_d   = 1'b0;
        pulse_cnt_d = '0;
      end
    endcase
  end

  // ---------------- display scan ----------------
  logic [SCAN_BITS-1:0] scan_cnt_q;
  logic [1:0]           idx;
  logic [31:0]          word;
  logic [15:0]          shadow_q, shadow_d;
  logic [3:0]           nibble;
  logic [6:0]           seg;
  logic [3:0]           anode_d;
  logic                 dp_d;

  assign idx  = scan_cnt_q[SCAN_BITS-1 -: 2];
  assign word = modeSel ? regValue : pcValue;

  // Snapshot at the start of each frame; the decode uses the next shadow
  // value so digit 0 of the new frame already shows the new snapshot.
  assign shadow_d = (scan_cnt_q == '0) ? (halfSel ? word[31:16] : word[15:0])
                                       : shadow_q;
  assign nibble   = shadow_d[{idx, 2'b00} +: 4];
  assign anode_d  = ~(4'b0001 << idx);
  assign dp_d     = !((idx == 2'd0) && modeSel);

  hex_to_seg u_hex_to_seg (
    .hex_i (nibble),
    .seg_o (seg)
  );

  // ---------------- registers ----------------
  logic [3:0] anode_q;
  logic [6:0] cathode_q;
  logic       dp_q;
  logic [4:0] reg_input_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      stable_q    <= 1'b0;
      deb_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      pulse_cnt_q <= '0;
      cpu_clk_q   <= 1'b0;
      scan_cnt_q  <= '0;
      shadow_q    <= '0;
      anode_q     <= 4'b1111;
      cathode_q   <= SEG_BLANK;
      dp_q        <= 1'b1;
      reg_input_q <= '0;
    end else begin
      sync1_q     <= stepBtn;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      cpu_clk_q   <= cpu_clk_d;
      scan_cnt_q  <= scan_cnt_q + SCAN_BITS'(1);
      shadow_q    <= shadow_d;
      anode_q     <= anode_d;
      cathode_q   <= seg;
      dp_q        <= dp_d;
      reg_input_q <= regSel;
    end
  end

  assign cpuClk   = cpu_clk_q;
  assign regInput = reg_input_q;
  assign anode    = anode_q;
  assign cathode  = cathode_q;
  assign dp       = dp_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_step_display_ctrl.sv
// Self-checking bench for step_display_ctrl with short debounce/pulse/scan
// parameters. A behavioural model derives expected outputs from the
// button history (synchroniser delay, run-length debounce) and frame timing.
module tb_step_display_ctrl;

  localparam int DEB      = 4;
  localparam int PUL      = 4;
  localparam int SBITS    = 4;
  localparam int SCAN_LEN = 1 << SBITS;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        stepBtn, modeSel, halfSel;
  logic [4:0]  regSel;
  logic [31:0] pcValue, regValue;
  logic        cpuClk, dp;
  logic [4:0]  regInput;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic [1:0]  dbgState;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  step_display_ctrl #(
    .DEBOUNCE_CYCLES (16'd4),
    .PULSE_CYCLES    (8'd4),
    .SCAN_BITS       (SBITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stepBtn  (stepBtn),
    .modeSel  (modeSel),
    .halfSel  (halfSel),
    .regSel   (regSel),
    .pcValue  (pcValue),
    .regValue (regValue),
    .cpuClk   (cpuClk),
    .regInput (regInput),
    .anode    (anode),
    .cathode  (cathode),
    .dp       (dp),
    .dbgState (dbgState)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];   // expected edge numbers of cpuClk rising

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model
  int          n_edge;
  int          m_cnt;
  logic [15:0] m_shadow;
  logic        btn_q[$];
  logic        win_q[$];
  logic        m_stable;
  bit          released;
  int          pulse_start;
  logic        exp_cpu, exp_dp;
  logic [3:0]  exp_anode;
  logic [6:0]  exp_cath;
  logic [4:0]  exp_reg;

  // monitor
  logic        prev_cpu;
  int          rises, hi_cycles;
  logic [6:0]  obs_cath [4];
  logic        obs_dp [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    m_cnt = 0;
    m_shadow = '0;
    btn_q.delete();
    btn_q.push_back(1'b0);
    btn_q.push_back(1'b0);
    win_q.delete();
    repeat (DEB) win_q.push_back(1'b0);
    m_stable = 1'b0;
    released = 1'b1;
    pulse_start = -100;
    exp_q.delete();
    exp_cpu = 1'b0;
    exp_anode = 4'b1111;
    exp_cath = 7'h7F;
    exp_dp = 1'b1;
    exp_reg = '0;
    prev_cpu = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using inputs present at the edge.
  task automatic model_step();
    logic        ds, s_before, all_diff;
    logic [31:0] word;
    int          c, idx;
    n_edge++;
    c = m_cnt;
    m_cnt = (m_cnt + 1) % SCAN_LEN;
    // the debouncer sees the button value from two edges earlier
    ds = btn_q.pop_front();
    btn_q.push_back(stepBtn);
    win_q.push_back(ds);
    if (win_q.size() > DEB) void'(win_q.pop_front());
    // stable flips once the last DEB observed values all disagree with it
    s_before = m_stable;
    all_diff = 1'b1;
    foreach (win_q[i]) if (win_q[i] == m_stable) all_diff = 1'b0;
    if (all_diff) m_stable = ~m_stable;
    if (all_diff && m_stable && released) begin
      pulse_start = n_edge;
      released = 1'b0;
      exp_q.push_back(32'(n_edge));
    end
    if (!released && n_edge > pulse_start + PUL && !s_before) released = 1'b1;
    exp_cpu = (n_edge >= pulse_start) && (n_edge < pulse_start + PUL);
    if (c == 0) begin
      word = modeSel ? regValue : pcValue;
      m_shadow = halfSel ? word[31:16] : word[15:0];
    end
    idx = c / (SCAN_LEN / 4);
    exp_anode = 4'b1111;
    exp_anode[idx] = 1'b0;
    exp_cath = seg_tbl[(m_shadow >> (4 * idx)) & 16'hF];
    exp_dp = !(idx == 0 && modeSel);
    exp_reg = regSel;
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cpuClk", 32'(cpuClk), 32'(exp_cpu));
    check("anode", 32'(anode), 32'(exp_anode));
    check("cathode", 32'(cathode), 32'(exp_cath));
    check("dp", 32'(dp), 32'(exp_dp));
    check("regInput", 32'(regInput), 32'(exp_reg));
    if (cpuClk && !prev_cpu) begin
      rises++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("pulse_edge", 32'(n_edge), e);
    end
    if (cpuClk) hi_cycles++;
    prev_cpu = cpuClk;
    case (anode)
      4'b1110: begin obs_cath[0] = cathode; obs_dp[0] = dp; end
      4'b1101: begin obs_cath[1] = cathode; obs_dp[1] = dp; end
      4'b1011: begin obs_cath[2] = cathode; obs_dp[2] = dp; end
      4'b0111: begin obs_cath[3] = cathode; obs_dp[3] = dp; end
      default: ;
    endcase
  endtask

  task automatic wait_frame_start();
    int g;
    g = 0;
    while (m_cnt != 0 && g < 2 * SCAN_LEN) begin
      tick();
      g++;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_cpuClk"}, 32'(cpuClk), 32'h0);
    check({pfx, "_anode"}, 32'(anode), 32'hF);
    check({pfx, "_cathode"}, 32'(cathode), 32'h7F);
    check({pfx, "_dp"}, 32'(dp), 32'h1);
    check({pfx, "_regInput"}, 32'(regInput), 32'h0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int press_n, rise_n, g, seg_left;
    logic btn_lvl;
    rst_n = 1'b0;
    stepBtn = 1'b0; modeSel = 1'b0; halfSel = 1'b0;
    regSel = '0; pcValue = '0; regValue = '0;
    rises = 0; hi_cycles = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    model_reset();

    // clean press held 20 cycles
    rises = 0; hi_cycles = 0; rise_n = -1;
    press_n = n_edge;
    stepBtn = 1'b1;
    repeat (20) begin
      tick();
      if (rises == 1 && rise_n < 0) rise_n = n_edge;
    end
    stepBtn = 1'b0;
    repeat (20) tick();
    check("press_latency", 32'(rise_n - press_n), 32'd6);
    check("pulse_width", 32'(hi_cycles), 32'(PUL));
    check("pulse_count", 32'(rises), 32'd1);

    // bounce: runs of 2 never survive the debouncer
    rises = 0; hi_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      stepBtn = ((i / 2) % 2) == 0;
      tick();
    end
    stepBtn = 1'b0;
    repeat (12) tick();
    check("bounce_pulses", 32'(rises), 32'd0);
    check("bounce_high", 32'(hi_cycles), 32'd0);

    // PC display
    modeSel = 1'b0; halfSel = 1'b0; pcValue = 32'h0040_A3F8;
    wait_frame_start();
    repeat (SCAN_LEN) tick();
    check("pc_d0", 32'(obs_cath[0]), 32'h00);
    check("pc_d1", 32'(obs_cath[1]), 32'h0E);
    check("pc_d2", 32'(obs_cath[2]), 32'h30);
    check("pc_d3", 32'(obs_cath[3]), 32'h08);
    check("pc_dp0", 32'(obs_dp[0]), 32'h1);

    // register mode, upper half
    modeSel = 1'b1; halfSel = 1'b1; regSel = 5'd16; regValue = 32'h1234_0000;
    tick();
    check("reg_input_latency", 32'(regInput), 32'd16);
    wait_frame_start();
    repeat (SCAN_LEN) tick();
    check("reg_d0", 32'(obs_cath[0]), 32'h19);
    check("reg_d1", 32'(obs_cath[1]), 32'h30);
    check("reg_d2", 32'(obs_cath[2]), 32'h24);
    check("reg_d3", 32'(obs_cath[3]), 32'h79);
    check("reg_dp0", 32'(obs_dp[0]), 32'h0);
    check("reg_dp3", 32'(obs_dp[3]), 32'h1);

    // tearing: change the PC mid-frame
    modeSel = 1'b0; halfSel = 1'b0; pcValue = 32'h0000_1111;
    wait_frame_start();
    repeat (SCAN_LEN) tick();
    g = 0;
    while (m_cnt != 5 && g < 2 * SCAN_LEN) begin tick(); g++; end
    pcValue = 32'h0000_2222;
    while (m_cnt != 0 && g < 4 * SCAN_LEN) begin tick(); g++; end
    check("tear_old_d3", 32'(obs_cath[3]), 32'h79);
    check("tear_old_d2", 32'(obs_cath[2]), 32'h79);
    repeat (SCAN_LEN) tick();
    check("tear_new_d0", 32'(obs_cath[0]), 32'h24);
    check("tear_new_d3", 32'(obs_cath[3]), 32'h24);

    // reset in the middle of a pulse
    stepBtn = 1'b1;
    g = 0;
    while (!cpuClk && g < 30) begin tick(); g++; end
    check("rst_pulse_seen", 32'(cpuClk), 32'h1);
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    stepBtn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rises = 0; hi_cycles = 0;
    repeat (20) tick();
    check("post_rst_pulses", 32'(rises), 32'd0);
    stepBtn = 1'b1;
    repeat (12) tick();
    stepBtn = 1'b0;
    repeat (12) tick();
    check("post_rst_new_press", 32'(rises), 32'd1);

    // randomized button timing and switch activity
    btn_lvl = 1'b0;
    seg_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (seg_left == 0) begin
        btn_lvl = ~btn_lvl;
        seg_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      seg_left--;
      stepBtn = btn_lvl;
      regSel = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) modeSel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) halfSel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) pcValue = $urandom;
      if ($urandom_range(0, 7) == 0) regValue = $urandom;
      tick();
    end
    stepBtn = 1'b0;
    repeat (20) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_display_ctrl.md
Name: step_display_ctrl

Overview:
- Board-level companion stage directly downstream of the pipelined MIPS core.
- Consumes the core's PC and register-file debug read port, and produces the core's `regInput` select.
- Generates the core's single-step clock from a debounced push-button.
- Time-multiplexes a 4-digit common-anode seven-segment display showing 16 bits of either the PC or the selected register, in hex.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive `clk` cycles the raw button must differ from the stable level before the stable level changes.
- PULSE_CYCLES, 8'd4, width of the `cpuClk` high phase in `clk` cycles.
- SCAN_BITS, 18, width of the refresh counter. The digit index is the top 2 bits.

Ports:
- clk  in  1  board clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stepBtn  in  1  raw, bouncy step button, active-high, asynchronous to `clk`.
- modeSel  in  1  0 = show PC, 1 = show register.
- halfSel  in  1  0 = bits [15:0], 1 = bits [31:16].
- regSel  in  5  register number requested by the switches.
- pcValue  in  32  PC from the core.
- regValue  in  32  register read data from the core.
- cpuClk  out  1  step clock to the core.
- regInput  out  5  register select to the core.
- anode  out  4  digit enables, active-low.
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (rst_n=0, immediate, mid-operation included):
  - cpuClk=0, anode=4'b1111, cathode=7'b1111111, dp=1, regInput=0.
  - All counters cleared, FSM=IDLE, stable button level=0, synchroniser flops=0.
- Button synchroniser: two-flop synchroniser on `stepBtn` feeds the debouncer.
- Debounce:
  - Counter increments while the synchronised input differs from `stable`, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, `stable` takes the input next cycle and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change `stable`.
- Step FSM (IDLE, HIGH, WAIT_REL):
  - IDLE: a rising edge of `stable` goes to HIGH; cpuClk rises on that same transition edge.
  - HIGH: cpuClk=1 for exactly PULSE_CYCLES cycles, then goes to WAIT_REL with cpuClk=0.
  - WAIT_REL: returns to IDLE when `stable`=0.
  - Exactly one cpuClk pulse per debounced press, regardless of hold time.
  - A release during HIGH does not shorten the pulse. After the pulse, the FSM passes through WAIT_REL to IDLE on the next cycle.
- regInput: registered copy of `regSel`, updated every cycle (1-cycle latency). It is not gated by the FSM.
- Scan:
  - Free-running counter of SCAN_BITS bits; wraps to 0 after all ones.
  - idx = cnt[SCAN_BITS-1:SCAN_BITS-2].
  - anode = ~(4'b0001 << idx), registered.
- Snapshot:
  - When cnt==0, shadow <= halfSel ? word[31:16] : word[15:0], where word = modeSel ? regValue : pcValue.
  - The digits display the shadow only, so one frame never mixes two values.
- Digit decode:
  - nibble = shadow[4*idx+3 -: 4]; digit 0 is the rightmost digit.
  - Standard hex decode: 0 -> 7'b1000000, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.
  - anode and cathode are registered together, so they change on the same edge.
  - dp=0 only when idx==0 and modeSel==1 (marks register mode); otherwise dp=1.
- First frame after reset: anode is all-off until the first registered update; the shadow is captured at cnt==0 on the first clock.

Decomposition:
- Shared package (debug_pkg): FSM state encodings (IDLE=2'd0, HIGH=2'd1, WAIT_REL=2'd2), a segment constant per hex value, and SEG_BLANK=7'h7F.
- Sub-module: hex_to_seg, a combinational 4-bit -> 7-bit decoder, instantiated once.
- Debounce, step FSM and scan logic stay in the top block.

Test Plan:
- Reset mid-pulse: DEBOUNCE_CYCLES=4, PULSE_CYCLES=4. Press, then assert rst_n=0 during HIGH -> cpuClk=0 and anode=4'b1111 immediately; no pulse after rst_n=1 until a new press.
- Clean press: hold stepBtn 20 cycles -> cpuClk rises 2+4 cycles after the press (synchroniser plus debounce); high exactly 4 cycles; exactly one pulse; no second pulse while held.
- Bounce: toggle stepBtn every 2 cycles for 16 cycles, then release -> stable stays 0 and cpuClk is never high.
- Display PC: SCAN_BITS=4, modeSel=0, halfSel=0, pcValue=32'h0040_A3F8 -> across one frame, anode 1110/1101/1011/0111 with cathode for 8/F/3/A; dp=1 throughout.
- Register mode: modeSel=1, halfSel=1, regSel=5'd16, regValue=32'h1234_0000 -> regInput=16 one cycle later; digits show 4,3,2,1 for idx 0..3; dp=0 only at idx 0.
- Tearing check: change pcValue mid-frame (cnt=5) -> the current frame keeps the old nibbles; the new value appears only after the cnt wrap to 0.
